count_arbiter: RTL and testbench
================================

COUNT_ARBITER -- requirements
Module: count_arbiter

Interface
REQ-001 Parameter W, default 4, width of the shared counter and of the length inputs.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  2  per-requester run request; bit i is requester i.
REQ-005 len0  input  W  requested final count for requester 0, sampled at grant.
REQ-006 len1  input  W  requested final count for requester 1, sampled at grant.
REQ-007 hold  input  1  pause; freezes the counter during RUN.
REQ-008 gnt  output  2  one-hot grant, registered; 2'b00 when no owner.
REQ-009 cnt  output  W  shared counter value, registered.
REQ-010 busy  output  1  high while state is RUN.
REQ-011 done  output  2  one-cycle completion pulse, bit i for requester i.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 IDLE with req==2'b00 SHALL stay in IDLE; gnt, done and busy are 0; cnt holds its value.
REQ-014 IDLE with exactly one req bit set SHALL grant that requester on the next edge: state RUN, gnt one-hot, cnt=0, len_q=len of the winner.
REQ-015 IDLE with req==2'b11 SHALL grant the requester not granted most recently (round-robin); last-owner pointer updates on each grant.
REQ-016 In RUN with hold=1, cnt, len_q and gnt SHALL hold.
REQ-017 In RUN with hold=0 and cnt!=len_q, cnt SHALL increment by 1 per cycle.
REQ-018 In RUN with hold=0 and cnt==len_q, the next state SHALL be DONE with gnt=0, cnt held at len_q, and done[owner]=1 for exactly that cycle.
REQ-019 Run length SHALL be len_q+1 unpaused RUN cycles; len_q=0 gives one RUN cycle with cnt=0.
REQ-020 cnt SHALL never exceed len_q, so no wrap-around occurs; all-ones length ends at cnt=2^W-1.
REQ-021 DONE SHALL go to IDLE unconditionally on the next edge with done=0.
REQ-022 A requester is re-arbitrated no earlier than 2 cycles after its done pulse.
REQ-023 If the owner's req bit is 0 in RUN (abort), the next state SHALL be IDLE with gnt=0, no done pulse and cnt held; abort takes priority over hold and over terminal count.
REQ-024 Changes to len0/len1 during RUN SHALL have no effect on the current run.
REQ-025 A non-owner request during RUN SHALL be ignored until IDLE.
REQ-026 busy SHALL equal (state==RUN); gnt SHALL be nonzero only in RUN.

Reset
REQ-027 rst=1 at a clock edge SHALL force state=IDLE, gnt=0, cnt=0, done=0, busy=0, len_q=0 and the last-owner pointer=1, so requester 0 wins the first contention.
REQ-028 Reset SHALL override every other input in the same cycle, including mid-RUN and DONE; no done pulse is issued.

Verification
REQ-029 Reset, then req=2'b01, len0=3, hold=0 -> gnt=01 one cycle later; cnt 0,1,2,3 over 4 cycles; then done=01 for one cycle, gnt=00, cnt=3; IDLE next.
REQ-030 req=2'b11 from reset, len0=1, len1=2, both held -> requester 0 runs first (done=01), then requester 1 (gnt=10, cnt 0..2, done=10), then requester 0 again.
REQ-031 Run with len0=5, hold=1 for 3 cycles at cnt=2 -> cnt stays 2 for 3 cycles; done asserts 3 cycles later than the unpaused run.
REQ-032 Requester 1 drops req at cnt=4 with len1=9 -> next cycle IDLE, gnt=00, cnt=4, done stays 00.
REQ-033 len0=0 -> one RUN cycle with cnt=0, then done=01; len0=15 -> cnt reaches 15 with no wrap, then done.
REQ-034 rst asserted at cnt=6 in RUN -> next edge gnt=00, cnt=0, done=00, busy=0; with req=2'b11 still held, requester 0 is granted first.

Source files
------------

// File: rtl/count_arbiter_if.sv
// Handshake bundle between requesters and the shared-counter arbiter.
interface count_arbiter_if #(
    parameter int W = 4
);
    logic [1:0]   req;
    logic [W-1:0] len0;
    logic [W-1:0] len1;
    logic         hold;
    logic [1:0]   gnt;
    logic [W-1:0] cnt;
    logic         busy;
    logic [1:0]   done;

    modport master (
        output req, len0, len1, hold,
        input  gnt, cnt, busy, done
    );

    modport slave (
        input  req, len0, len1, hold,
        output gnt, cnt, busy, done
    );
endinterface

// File: rtl/count_arbiter.sv
// Two-requester round-robin arbiter that lends one shared up-counter to the
// winner. A run counts 0..len_q, pulses done for the owner, then returns to
// IDLE. The owner dropping its request aborts the run silently.
module count_arbiter #(
    parameter int W = 4
) (
    input  logic            clk,
    input  logic            rst,
    count_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   state;
    logic [1:0]   gnt_q;
    logic [W-1:0] cnt_q;
    logic [W-1:0] len_q;
    logic [1:0]   done_q;
    logic         last;      // index of the most recently granted requester
    logic         owner;     // index of the current owner (valid in RUN)
    logic         winner;    // arbitration result in IDLE
    logic         any_req;

    assign owner   = gnt_q[1];
    assign any_req = |bus.req;

    // Single request wins outright; on contention the one not served last wins.
    always_comb begin
        winner = 1'b0;
        case (bus.req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last;
            default: winner = 1'b0;
        endcase
    end

    // Arbitration, counting and completion sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            gnt_q  <= 2'b00;
            cnt_q  <= '0;
            len_q  <= '0;
            done_q <= 2'b00;
            last   <= 1'b1;
        end else begin
            done_q <= 2'b00;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state  <= RUN;
                        gnt_q  <= winner ? 2'b10 : 2'b01;
                        cnt_q  <= '0;
                        len_q  <= winner ? bus.len1 : bus.len0;
                        last   <= winner;
                    end
                end
                RUN: begin
                    // Abort outranks both hold and terminal count.
                    if (!bus.req[owner]) begin
                        state <= IDLE;
                        gnt_q <= 2'b00;
                    end else if (bus.hold) begin
                        state <= RUN;
                    end else if (cnt_q == len_q) begin
                        state         <= DONE;
                        gnt_q         <= 2'b00;
                        done_q[owner] <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    gnt_q <= 2'b00;
                end
            endcase
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.cnt  = cnt_q;
    assign bus.done = done_q;
    assign bus.busy = (state == RUN);
endmodule

// File: tb/tb_count_arbiter.sv
// Directed bench for count_arbiter: hand-computed expectations per cycle.
module tb_count_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    count_arbiter_if #(.W(4)) bus ();

    count_arbiter #(.W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Compare the full output set; busy is implied by a nonzero grant.
    task automatic expect_st(input string tag, input logic [1:0] g,
                             input logic [3:0] c, input logic [1:0] d);
        chk({tag, ".gnt"},  {30'd0, bus.gnt},  {30'd0, g});
        chk({tag, ".cnt"},  {28'd0, bus.cnt},  {28'd0, c});
        chk({tag, ".done"}, {30'd0, bus.done}, {30'd0, d});
        chk({tag, ".busy"}, {31'd0, bus.busy}, {31'd0, (g != 2'b00)});
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.req  = 2'b00;
        bus.len0 = 4'd0;
        bus.len1 = 4'd0;
        bus.hold = 1'b0;
        tick();
        tick();
        expect_st("reset", 2'b00, 4'd0, 2'b00);
        rst = 1'b0;

        // Single requester, len 3.
        bus.len0 = 4'd3;
        bus.req  = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_st($sformatf("r0_len3_c%0d", i), 2'b01, 4'(i), 2'b00);
        end
        tick();
        expect_st("r0_len3_done", 2'b00, 4'd3, 2'b01);
        bus.req = 2'b00;
        tick();
        expect_st("r0_len3_idle", 2'b00, 4'd3, 2'b00);
        tick();
        expect_st("idle_hold_cnt", 2'b00, 4'd3, 2'b00);

        // Contention from reset: round-robin 0, 1, 0.
        do_reset();
        bus.req  = 2'b11;
        bus.len0 = 4'd1;
        bus.len1 = 4'd2;
        tick(); expect_st("rr_a0", 2'b01, 4'd0, 2'b00);
        tick(); expect_st("rr_a1", 2'b01, 4'd1, 2'b00);
        tick(); expect_st("rr_adone", 2'b00, 4'd1, 2'b01);
        tick(); expect_st("rr_aidle", 2'b00, 4'd1, 2'b00);
        tick(); expect_st("rr_b0", 2'b10, 4'd0, 2'b00);
        tick(); expect_st("rr_b1", 2'b10, 4'd1, 2'b00);
        tick(); expect_st("rr_b2", 2'b10, 4'd2, 2'b00);
        tick(); expect_st("rr_bdone", 2'b00, 4'd2, 2'b10);
        tick(); expect_st("rr_bidle", 2'b00, 4'd2, 2'b00);
        tick(); expect_st("rr_c0", 2'b01, 4'd0, 2'b00);
        bus.req = 2'b00;
        tick(); expect_st("abort_at0", 2'b00, 4'd0, 2'b00);

        // Hold for 3 cycles at cnt=2; length change mid-run is ignored.
        bus.req  = 2'b01;
        bus.len0 = 4'd5;
        tick(); expect_st("hold_c0", 2'b01, 4'd0, 2'b00);
        tick(); expect_st("hold_c1", 2'b01, 4'd1, 2'b00);
        tick(); expect_st("hold_c2", 2'b01, 4'd2, 2'b00);
        bus.hold = 1'b1;
        bus.len0 = 4'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_st($sformatf("hold_frz%0d", i), 2'b01, 4'd2, 2'b00);
        end
        bus.hold = 1'b0;
        tick(); expect_st("hold_c3", 2'b01, 4'd3, 2'b00);
        tick(); expect_st("hold_c4", 2'b01, 4'd4, 2'b00);
        tick(); expect_st("hold_c5", 2'b01, 4'd5, 2'b00);
        tick(); expect_st("hold_done", 2'b00, 4'd5, 2'b01);
        bus.req = 2'b00;
        tick(); expect_st("hold_idle", 2'b00, 4'd5, 2'b00);

        // Requester 1 aborts at cnt=4; a non-owner request is ignored mid-run.
        bus.len1 = 4'd9;
        bus.len0 = 4'd0;
        bus.req  = 2'b10;
        tick(); expect_st("ab_c0", 2'b10, 4'd0, 2'b00);
        tick(); expect_st("ab_c1", 2'b10, 4'd1, 2'b00);
        bus.req = 2'b11;
        tick(); expect_st("ab_c2_nonowner", 2'b10, 4'd2, 2'b00);
        tick(); expect_st("ab_c3", 2'b10, 4'd3, 2'b00);
        tick(); expect_st("ab_c4", 2'b10, 4'd4, 2'b00);
        bus.req = 2'b01;
        tick(); expect_st("ab_idle", 2'b00, 4'd4, 2'b00);

        // len0=0: a single RUN cycle at cnt=0.
        tick(); expect_st("len0_run", 2'b01, 4'd0, 2'b00);
        tick(); expect_st("len0_done", 2'b00, 4'd0, 2'b01);
        bus.req = 2'b00;
        tick(); expect_st("len0_idle", 2'b00, 4'd0, 2'b00);

        // len0=15: count to all-ones with no wrap.
        bus.len0 = 4'd15;
        bus.req  = 2'b01;
        for (int i = 0; i < 16; i++) begin
            tick();
            expect_st($sformatf("max_c%0d", i), 2'b01, 4'(i), 2'b00);
        end
        tick(); expect_st("max_done", 2'b00, 4'd15, 2'b01);
        bus.req = 2'b00;
        tick(); expect_st("max_idle", 2'b00, 4'd15, 2'b00);

        // Reset mid-run at cnt=6 with both requesting; last owner was 0 so 1 wins first.
        bus.len0 = 4'd8;
        bus.len1 = 4'd8;
        bus.req  = 2'b11;
        tick(); expect_st("rst_run_c0", 2'b10, 4'd0, 2'b00);
        for (int i = 1; i <= 6; i++) tick();
        expect_st("rst_run_c6", 2'b10, 4'd6, 2'b00);
        rst = 1'b1;
        tick(); expect_st("rst_mid", 2'b00, 4'd0, 2'b00);
        rst = 1'b0;
        tick(); expect_st("rst_first_win", 2'b01, 4'd0, 2'b00);

        // Reset landing on the DONE cycle: no further pulse, straight to IDLE.
        bus.len0 = 4'd0;
        do_reset();
        tick(); expect_st("rd_run", 2'b01, 4'd0, 2'b00);
        tick(); expect_st("rd_done", 2'b00, 4'd0, 2'b01);
        bus.req = 2'b00;
        rst = 1'b1;
        tick(); expect_st("rd_rst", 2'b00, 4'd0, 2'b00);
        rst = 1'b0;
        tick(); expect_st("rd_idle", 2'b00, 4'd0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
